// File: rtl/k005297_bubwrser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | k005297_bubwrser : page bytes -> preamble + MSB-first serial bubble stream |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module k005297_bubwrser #(
  parameter int         PAGE_BYTES    = 64,
  parameter int         PREAMBLE_BITS = 8,
  parameter logic [7:0] PREAMBLE_PAT  = 8'hA5
) (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_CLK2M_PCEN_n,
  input  logic [19:0] i_ROT20_n,
  input  logic        i_4BEN_n,
  input  logic        i_WRSTART,
  input  logic        i_ABORT,
  input  logic [7:0]  i_BYTE,
  input  logic        i_BYTE_WR,
  output logic        o_BYTE_REQ,
  output logic        o_MUXED_BDO,
  output logic        o_MUXED_BDO_EN,
  output logic        o_SUPBD_END_n,
  output logic        o_UNDERRUN,
  output logic        o_BUSY
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;

  localparam logic [7:0] C_PAGE = 8'(PAGE_BYTES);
  localparam logic [3:0] C_PRE  = 4'(PREAMBLE_BITS);

  logic [2:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] acc_cnt_q, acc_cnt_d;
  logic [7:0] ld_cnt_q, ld_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] shift_q, shift_d;
  logic       bdo_q, bdo_d;
  logic       en_q, en_d;
  logic       end_n_q, end_n_d;
  logic       underrun_q, underrun_d;
  logic       byte_req_q, byte_req_d;
  logic       busy_q, busy_d;

  logic       et, at;
  logic       start, load, arm_pre, pre_bit, shift, drop_en, accept;
  logic [2:0] pat_idx;
  logic       unused_rot;

  assign et = ~i_CLK2M_PCEN_n;
  assign at = et & (~i_ROT20_n[2] | ~i_ROT20_n[7] |
                    (~i_4BEN_n & (~i_ROT20_n[12] | ~i_ROT20_n[17])));
  // Only steps 2/7/12/17 pace the stream; the rest of the rotation is ignored.
  assign unused_rot = ^i_ROT20_n;
  assign pat_idx    = 3'(4'd7 - bit_cnt_q);

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      acc_cnt_q  <= 8'd0;
      ld_cnt_q   <= 8'd0;
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
      shift_q    <= 8'd0;
      bdo_q      <= 1'b0;
      en_q       <= 1'b0;
      end_n_q    <= 1'b1;
      underrun_q <= 1'b0;
      byte_req_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      ld_cnt_q   <= ld_cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      bdo_q      <= bdo_d;
      en_q       <= en_d;
      end_n_q    <= end_n_d;
      underrun_q <= underrun_d;
      byte_req_q <= byte_req_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    load    = 1'b0;
    arm_pre = 1'b0;
    pre_bit = 1'b0;
    shift   = 1'b0;
    drop_en = 1'b0;
    if (et) begin
      case (state_q)
        S_IDLE: begin
          if (i_WRSTART) begin
            state_d = S_ARM;
            start   = 1'b1;
          end
        end
        S_ARM: begin
          if (i_ABORT) begin
            state_d = S_IDLE;
            drop_en = 1'b1;
          end else if (at) begin
            if (C_PRE == 4'd0) begin
              load    = 1'b1;
              state_d = S_DATA;
            end else begin
              arm_pre = 1'b1;
              state_d = S_PRE;
            end
          end
        end
        S_PRE: begin
          if (i_ABORT) begin
            state_d = S_IDLE;
            drop_en = 1'b1;
          end else if (at) begin
            if (bit_cnt_q == C_PRE) begin
              load    = 1'b1;
              state_d = S_DATA;
            end else begin
              pre_bit = 1'b1;
            end
          end
        end
        S_DATA: begin
          if (i_ABORT) begin
            state_d = S_IDLE;
            drop_en = 1'b1;
          end else if (at) begin
            if (bit_cnt_q != 4'd0) begin
              shift = 1'b1;
            end else if (ld_cnt_q < C_PAGE) begin
              load = 1'b1;
            end else begin
              drop_en = 1'b1;
              state_d = S_END;
            end
          end
        end
        S_END:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    ld_cnt_d   = ld_cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    bdo_d      = bdo_q;
    en_d       = en_q;
    end_n_d    = end_n_q;
    underrun_d = underrun_q;
    accept     = 1'b0;

    if (start) begin
      bit_cnt_d  = 4'd0;
      acc_cnt_d  = 8'd0;
      ld_cnt_d   = 8'd0;
      hold_vld_d = 1'b0;
      underrun_d = 1'b0;
    end
    if (arm_pre) begin
      en_d      = 1'b1;
      bdo_d     = PREAMBLE_PAT[7];
      bit_cnt_d = 4'd1;
    end
    if (pre_bit) begin
      bdo_d     = PREAMBLE_PAT[pat_idx];
      bit_cnt_d = bit_cnt_q + 4'd1;
    end
    if (shift) begin
      shift_d   = {shift_q[6:0], 1'b0};
      bdo_d     = shift_q[6];
      bit_cnt_d = bit_cnt_q - 4'd1;
    end
    // A missing byte still consumes its slot so the page length never changes.
    if (load) begin
      en_d      = 1'b1;
      bit_cnt_d = 4'd7;
      ld_cnt_d  = ld_cnt_q + 8'd1;
      if (hold_vld_q) begin
        shift_d    = hold_q;
        bdo_d      = hold_q[7];
        hold_vld_d = 1'b0;
      end else begin
        shift_d    = 8'd0;
        bdo_d      = 1'b0;
        underrun_d = 1'b1;
      end
    end
    if (drop_en) begin
      en_d  = 1'b0;
      bdo_d = 1'b0;
    end
    if (et) begin
      end_n_d = (state_q != S_END);
    end

    accept = i_BYTE_WR && (acc_cnt_q < C_PAGE) && (byte_req_q || (load && hold_vld_q));
    if (accept) begin
      hold_d     = i_BYTE;
      hold_vld_d = 1'b1;
      acc_cnt_d  = acc_cnt_q + 8'd1;
    end
  end

  always_comb begin
    byte_req_d = ~hold_vld_d && (state_d == S_ARM || state_d == S_PRE || state_d == S_DATA)
                 && (acc_cnt_d < C_PAGE);
    busy_d     = (state_d != S_IDLE);
  end

  assign o_BYTE_REQ     = byte_req_q;
  assign o_MUXED_BDO    = bdo_q;
  assign o_MUXED_BDO_EN = en_q;
  assign o_SUPBD_END_n  = end_n_q;
  assign o_UNDERRUN     = underrun_q;
  assign o_BUSY         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_k005297_bubwrser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_k005297_bubwrser : directed bench for the bubble write serializer       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_k005297_bubwrser;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcen_n;
  logic [19:0] rot_n;
  logic        mode4n;
  logic        wrstart, abort;
  logic [7:0]  wbyte;
  logic        wr;
  logic        req, bdo, en, endn, urun, busy;

  k005297_bubwrser #(.PAGE_BYTES(2), .PREAMBLE_BITS(8), .PREAMBLE_PAT(8'hA5)) dut (
    .i_MCLK(clk), .i_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_ROT20_n(rot_n),
    .i_4BEN_n(mode4n), .i_WRSTART(wrstart), .i_ABORT(abort), .i_BYTE(wbyte),
    .i_BYTE_WR(wr), .o_BYTE_REQ(req), .o_MUXED_BDO(bdo), .o_MUXED_BDO_EN(en),
    .o_SUPBD_END_n(endn), .o_UNDERRUN(urun), .o_BUSY(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int page_id  = 0;

  // feeder configuration (main writes, feeder reads)
  logic [7:0] feed_data [2];
  int         feed_n      = 0;
  int         inject_at   = -1;
  logic [7:0] inject_byte = 8'h00;

  // monitor results (monitor writes, main reads)
  int          rot_idx = 0;
  int          phase   = 0;
  int          et_cnt = 0, nbits = 0, first_et = 0, last_et = 0;
  int          end_pulses = 0, bad_timing = 0, m_seen = 0;
  logic [63:0] bits = 64'd0;
  logic        m_et, m_at, prev_en, prev_bdo, prev_endn;

  function automatic bit at_step(input int s, input logic m4n);
    return (s == 2) || (s == 7) || (!m4n && ((s == 12) || (s == 17)));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 2 MHz enable every 4th MCLK; rotation advances after each enable tick
  initial begin
    pcen_n = 1'b1;
    rot_n  = ~20'd1;
    forever begin
      @(posedge clk);
      #2;
      if (!pcen_n) rot_idx = (rot_idx + 1) % 20;
      phase  = (phase + 1) % 4;
      pcen_n = (phase != 3);
      rot_n  = ~(20'd1 << rot_idx);
    end
  end

  initial begin
    prev_en = 1'b0; prev_bdo = 1'b0; prev_endn = 1'b1;
    forever begin
      @(posedge clk);
      m_et = !pcen_n;
      m_at = m_et && at_step(rot_idx, mode4n);
      #1;
      if (page_id != m_seen) begin
        m_seen = page_id; nbits = 0; bits = 64'd0; end_pulses = 0;
        bad_timing = 0; first_et = 0; last_et = 0;
      end
      if (m_et) et_cnt++;
      if (!rst) begin
        if (m_at && en) begin
          if (nbits == 0) first_et = et_cnt;
          last_et = et_cnt;
          bits    = {bits[62:0], bdo};
          nbits++;
        end
        if (m_et && !endn) end_pulses++;
        if (!m_at && (en != prev_en || bdo != prev_bdo)) bad_timing++;
        if (!m_et && endn != prev_endn) bad_timing++;
      end
      prev_en = en; prev_bdo = bdo; prev_endn = endn;
    end
  end

  // byte feeder: answers BYTE_REQ, or injects one write just before a chosen AT
  initial begin
    int  f_seen = 0;
    int  f_idx  = 0;
    bit  f_inj  = 1'b0;
    wr = 1'b0; wbyte = 8'h00;
    forever begin
      @(negedge clk);
      if (page_id != f_seen) begin f_seen = page_id; f_idx = 0; f_inj = 1'b0; end
      if (wr) begin
        wr = 1'b0;
      end else if (inject_at >= 0 && !f_inj && nbits == inject_at &&
                   !pcen_n && at_step(rot_idx, mode4n)) begin
        wbyte = inject_byte; wr = 1'b1; f_inj = 1'b1;
      end else if (req && f_idx < feed_n) begin
        wbyte = feed_data[f_idx]; f_idx++; wr = 1'b1;
      end
    end
  end

  task automatic start_page();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!pcen_n && rot_idx == 0) break;
    end
    wrstart = 1'b1;
    @(negedge clk);
    wrstart = 1'b0;
  endtask

  task automatic wait_bits(input int k, input string tag);
    for (int i = 0; i < 4000; i++) begin
      if (nbits >= k) break;
      @(negedge clk);
    end
    check({tag, "_bits_to"}, 32'(nbits >= k), 32'd1);
  endtask

  task automatic run_page(input bit m4, input logic [7:0] b0, input logic [7:0] b1,
                          input int nf, input int inj, input bit exp_ur,
                          input bit mid_start, input string tag);
    logic [7:0] eb1;
    mode4n = !m4;
    feed_data[0] = b0; feed_data[1] = b1;
    feed_n = nf; inject_at = inj; inject_byte = b1;
    page_id++;
    start_page();
    check({tag, "_urun_clr"}, 32'(urun), 32'd0);
    if (mid_start) begin
      wait_bits(5, tag);
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (!pcen_n) break; end
      wrstart = 1'b1;
      @(negedge clk);
      wrstart = 1'b0;
    end
    for (int i = 0; i < 4000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check({tag, "_idle_to"}, 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    eb1 = exp_ur ? 8'h00 : b1;
    check({tag, "_nbits"}, 32'(nbits), 32'd24);
    check({tag, "_stream"}, {8'h00, bits[23:0]}, {8'h00, 8'hA5, b0, eb1});
    check({tag, "_end_pulses"}, 32'(end_pulses), 32'd1);
    check({tag, "_span"}, 32'(last_et - first_et), m4 ? 32'd115 : 32'd225);
    check({tag, "_timing"}, 32'(bad_timing), 32'd0);
    check({tag, "_post"}, {26'd0, bdo, en, endn, req, urun, busy},
          {26'd0, 1'b0, 1'b0, 1'b1, 1'b0, exp_ur, 1'b0});
  endtask

  initial begin
    int nb;
    rst = 1'b1; wrstart = 1'b0; abort = 1'b0; mode4n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vals", {26'd0, bdo, en, endn, req, urun, busy}, 32'b001000);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_vals", {26'd0, bdo, en, endn, req, urun, busy}, 32'b001000);

    run_page(1'b1, 8'h3C, 8'hF0, 2, -1, 1'b0, 1'b0, "p4");
    run_page(1'b0, 8'h3C, 8'hF0, 2, -1, 1'b0, 1'b0, "p2");
    run_page(1'b1, 8'h3C, 8'hF0, 1, -1, 1'b1, 1'b0, "urun");
    run_page(1'b1, 8'h3C, 8'h5A, 1,  8, 1'b0, 1'b0, "simul");
    run_page(1'b1, 8'h96, 8'h69, 2, -1, 1'b0, 1'b1, "midst");

    // abort during DATA
    mode4n = 1'b0;
    feed_data[0] = 8'h3C; feed_data[1] = 8'hF0; feed_n = 2; inject_at = -1;
    page_id++;
    start_page();
    wait_bits(12, "abort");
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (!pcen_n) break; end
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_now", {29'd0, en, bdo, busy}, 32'd0);
    nb = nbits;
    @(negedge clk);
    abort = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_no_end", 32'(end_pulses), 32'd0);
    check("abort_no_bits", 32'(nbits), 32'(nb));
    check("abort_endn", 32'(endn), 32'd1);

    // asynchronous reset mid-DATA, then a fresh page
    page_id++;
    feed_n = 2;
    start_page();
    wait_bits(12, "rst");
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_async", {26'd0, bdo, en, endn, req, urun, busy}, 32'b001000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_page(1'b1, 8'hC3, 8'hE7, 2, -1, 1'b0, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/k005297_bubwrser.md
# k005297_bubwrser

Bubble write serializer: the stage directly upstream of the bubble write front end. It takes page bytes from the page-buffer side through a one-byte holding register. It emits them MSB-first as a single bit stream (`o_MUXED_BDO`/`o_MUXED_BDO_EN`), prefixed by a fixed preamble and paced by the 20-step rotation timing in 2-bit or 4-bit mode. At page end it pulses `o_SUPBD_END_n`, which the front end uses to drop its output enable.

## Interface
Parameters:
- `PAGE_BYTES`, 64: data bytes per page, 1..255
- `PREAMBLE_BITS`, 8: preamble length, 0..8
- `PREAMBLE_PAT`, 8'hA5: preamble pattern, sent from bit 7 downward

Ports:
- `i_MCLK` in 1: master clock; sole clock
- `i_RST` in 1: asynchronous, active-high reset
- `i_CLK2M_PCEN_n` in 1: 2 MHz clock enable, active low
- `i_ROT20_n` in 20: one-hot-low rotation step, advances on enable ticks
- `i_4BEN_n` in 1: 0 = 4-bit mode, 1 = 2-bit mode
- `i_WRSTART` in 1: start page, sampled on enable ticks
- `i_ABORT` in 1: abandon page, sampled on enable ticks
- `i_BYTE` in 8: write byte
- `i_BYTE_WR` in 1: one-MCLK write strobe
- `o_BYTE_REQ` out 1: holding register wants a byte
- `o_MUXED_BDO` out 1: serial bubble data
- `o_MUXED_BDO_EN` out 1: serial data valid
- `o_SUPBD_END_n` out 1: page-end pulse, active low
- `o_UNDERRUN` out 1: sticky, a byte was missing when needed
- `o_BUSY` out 1: state ≠ IDLE

## Operation
Tick definitions:
- Enable tick (ET): `i_MCLK` rising edge with `i_CLK2M_PCEN_n`=0.
- Advance tick (AT): an ET with `i_ROT20_n[2]` or `[7]` low, or in 4-bit mode also `[12]` or `[17]` low.
- ATs fall one step before the front end's shift steps 3/8/13/18, so each bit is stable when sampled.

Counters:
- 4-bit preamble/bit counter.
- 8-bit count of bytes accepted.
- 8-bit count of bytes loaded.

State machine, all transitions on ET only:
- IDLE → ARM: `i_WRSTART`=1. Clears counters and `o_UNDERRUN`, and empties the holding register. `i_WRSTART` in any other state is ignored.
- ARM → PRE on the next AT: `o_MUXED_BDO_EN`←1, BDO←`PREAMBLE_PAT[7]`. If `PREAMBLE_BITS`=0, go straight to DATA and perform a byte load instead.
- PRE: each AT presents the next pattern bit. The AT after bit `PREAMBLE_BITS`-1 performs a byte load and moves to DATA.
- DATA: each AT shifts out the next bit, MSB first. After bit 0 of a byte:
  - If bytes loaded < `PAGE_BYTES`, perform a byte load.
  - Otherwise BDO←0, EN←0, go to END.
- END: the next ET drives `o_SUPBD_END_n`=0 for exactly one ET period, then returns to IDLE.
- `i_ABORT`=1 in ARM, PRE or DATA: the next ET goes to IDLE with EN=0, BDO=0, and no end pulse.

Byte load:
- Holding register valid: shifter←holding, BDO←holding[7], holding becomes empty.
- Holding register empty: shifter←0, BDO←0, `o_UNDERRUN`←1. The byte slot is still counted as loaded.

Holding register:
- `o_BYTE_REQ` = holding empty AND state ∈ {ARM, PRE, DATA} AND accepted < `PAGE_BYTES`.
- `i_BYTE_WR` is accepted when `o_BYTE_REQ`=1, or when a load empties the register in the same MCLK cycle. In that case the old byte is loaded, the new byte is stored, and valid stays 1.
- Any other write is dropped.

## Timing
- Reset values: BDO=0, EN=0, SUPBD_END_n=1, BYTE_REQ=0, UNDERRUN=0, BUSY=0. State = IDLE, holding register empty.
- `i_RST` asserted mid-page forces the reset values immediately, with no end pulse.
- All outputs are registered. BDO and EN change only on ATs; SUPBD_END_n changes only on ETs.
- Bits per rotation: 2-bit mode 2 (steps 2, 7); 4-bit mode 4.
- Page length on the wire: `PREAMBLE_BITS` + 8·`PAGE_BYTES` consecutive ATs with EN=1.
- Latency from the starting ET to the first bit is up to one rotation (the first AT).
- `o_BYTE_REQ` rises in the MCLK cycle after the register empties.
- Mode change mid-page takes effect at the next AT.

## Test plan
- 4-bit mode, `PAGE_BYTES`=2, bytes 8'h3C, 8'hF0 supplied promptly → 24 ATs with EN=1 carrying A5, 3C, F0 MSB-first. Then EN=0, one SUPBD_END_n low ET, BUSY=0, UNDERRUN=0.
- 2-bit mode, same page → bits appear only at steps 2/7. The page spans 12 rotations.
- Withhold the second byte → its 8 bits are 0, UNDERRUN=1 and stays 1 until the next `i_WRSTART`. The end pulse still occurs.
- `i_BYTE_WR` in the same MCLK cycle as a load with the holding register full → old byte shifted, new byte retained. The following byte on the wire equals the new byte.
- `i_ABORT` during DATA → EN=0 and BUSY=0 within one ET, no end pulse. `i_WRSTART` during an active page is ignored.
- `i_RST` pulsed mid-DATA → all outputs at reset values asynchronously. A fresh page afterwards is bit-exact.
